// File: rtl/bus_unit.sv
// Load/store bus unit: one access at a time. The unit steers sub-word store data
// onto byte lanes and extracts and extends sub-word load data. Misaligned or
// illegal requests, and targets that stall too long, are answered with an error.
module bus_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_signed,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_error,
    output logic [ADDR_WIDTH-1:0]   address,
    output logic [DATA_WIDTH-1:0]   dataOut,
    input  logic [DATA_WIDTH-1:0]   dataIn,
    output logic                    busWriteEnable,
    output logic [DATA_WIDTH/8-1:0] busByteEnable,
    output logic                    busValid,
    input  logic                    busReady
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFW  = $clog2(BYTES);
    localparam int CW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state_reg, state_next;

    // Request decode (combinational, used only at accept time)
    logic [OFFW-1:0]       reqOff;
    logic [3:0]            reqBytes;
    logic                  reqIllegal;
    logic                  accept;
    logic [DATA_WIDTH-1:0] wdataShifted;
    logic [DATA_WIDTH-1:0] steeredData;
    logic [BYTES-1:0]      laneEnable;

    // Latched access attributes needed to post-process load data
    logic [OFFW-1:0]       accOff_reg;
    logic [1:0]            accSize_reg;
    logic                  accSigned_reg;
    logic [3:0]            accBytes;
    logic [DATA_WIDTH-1:0] shiftedIn;
    logic [DATA_WIDTH-1:0] keepMask;
    logic [DATA_WIDTH-1:0] loadValue;
    logic                  signBit;

    logic [CW-1:0]           waitCount_reg;
    logic                    timeoutHit;
    logic                    busValid_reg;
    logic                    busWriteEnable_reg;
    logic [ADDR_WIDTH-1:0]   address_reg;
    logic [DATA_WIDTH-1:0]   dataOut_reg;
    logic [BYTES-1:0]        busByteEnable_reg;
    logic                    respValid_reg;
    logic                    respError_reg;
    logic [DATA_WIDTH-1:0]   respRdata_reg;

    assign req_ready  = (state_reg == IDLE) && !reset;
    assign accept     = req_valid && req_ready;
    assign reqOff     = req_addr[OFFW-1:0];
    assign reqBytes   = 4'd1 << req_size;
    // A dword on a 32-bit bus has no lanes to live in; otherwise natural alignment is required.
    assign reqIllegal = ((req_size == 2'd3) && (DATA_WIDTH == 32)) ||
                        ((reqOff & OFFW'(reqBytes - 4'd1)) != '0);
    assign wdataShifted = req_wdata << {reqOff, 3'b000};

    assign accBytes  = 4'd1 << accSize_reg;
    assign shiftedIn = dataIn >> {accOff_reg, 3'b000};
    assign timeoutHit = (TIMEOUT_CYCLES != 0) && (waitCount_reg == CW'(TIMEOUT_CYCLES));

    // Per-lane enables, store steering and the load keep-mask
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            assign laneEnable[gi] = (gi >= int'(reqOff)) && (gi < int'(reqOff) + int'(reqBytes));
            assign steeredData[8*gi +: 8] = laneEnable[gi] ? wdataShifted[8*gi +: 8] : 8'h00;
            assign keepMask[8*gi +: 8]    = (gi < int'(accBytes)) ? 8'hFF : 8'h00;
        end
    endgenerate

    // Pick the top bit of the loaded item for sign extension
    always_comb begin
        signBit = shiftedIn[DATA_WIDTH-1];
        case (accSize_reg)
            2'd0:    signBit = shiftedIn[7];
            2'd1:    signBit = shiftedIn[15];
            2'd2:    signBit = shiftedIn[31];
            default: signBit = shiftedIn[DATA_WIDTH-1];
        endcase
    end

    // Full-width loads have an all-ones keep-mask, so extension is a no-op for them
    assign loadValue = (shiftedIn & keepMask) |
                       ((accSigned_reg && signBit) ? ~keepMask : '0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = reqIllegal ? RESP : ACCESS;
            ACCESS:  if (busReady || timeoutHit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus-side and response registers; completion takes priority over timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            busValid_reg       <= 1'b0;
            busWriteEnable_reg <= 1'b0;
            address_reg        <= '0;
            dataOut_reg        <= '0;
            busByteEnable_reg  <= '0;
            respValid_reg      <= 1'b0;
            respError_reg      <= 1'b0;
            respRdata_reg      <= '0;
            waitCount_reg      <= '0;
            accOff_reg         <= '0;
            accSize_reg        <= '0;
            accSigned_reg      <= 1'b0;
        end else begin
            respValid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (reqIllegal) begin
                            respValid_reg <= 1'b1;
                            respError_reg <= 1'b1;
                            respRdata_reg <= '0;
                        end else begin
                            busValid_reg       <= 1'b1;
                            busWriteEnable_reg <= req_write;
                            address_reg        <= {req_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
                            dataOut_reg        <= steeredData;
                            busByteEnable_reg  <= laneEnable;
                            waitCount_reg      <= '0;
                            accOff_reg         <= reqOff;
                            accSize_reg        <= req_size;
                            accSigned_reg      <= req_signed;
                        end
                    end
                end
                ACCESS: begin
                    if (busReady) begin
                        busValid_reg       <= 1'b0;
                        busWriteEnable_reg <= 1'b0;
                        respValid_reg      <= 1'b1;
                        respError_reg      <= 1'b0;
                        respRdata_reg      <= busWriteEnable_reg ? '0 : loadValue;
                    end else if (timeoutHit) begin
                        busValid_reg       <= 1'b0;
                        busWriteEnable_reg <= 1'b0;
                        respValid_reg      <= 1'b1;
                        respError_reg      <= 1'b1;
                        respRdata_reg      <= '0;
                    end else begin
                        waitCount_reg <= waitCount_reg + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busValid       = busValid_reg;
    assign busWriteEnable = busWriteEnable_reg;
    assign address        = address_reg;
    assign dataOut        = dataOut_reg;
    assign busByteEnable  = busByteEnable_reg;
    assign resp_valid     = respValid_reg;
    assign resp_error     = respError_reg;
    assign resp_rdata     = respRdata_reg;
endmodule
